// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, instruction
// field positions and small field-extraction helpers.
package seq_pkg;

    localparam int INSTR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_FAULT = 3'd3,
        ST_PAUSE = 3'd4
    } seq_state_e;

    localparam int ADDR_LSB   = 0;
    localparam int ADDR_MSB   = 1;
    localparam int OP_LSB     = 2;
    localparam int OP_MSB     = 4;
    localparam int ACC_CE_BIT = 5;

    function automatic logic instr_acc_ce(input logic [INSTR_W-1:0] instr);
        return instr[ACC_CE_BIT];
    endfunction

    function automatic logic [2:0] instr_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Bundle of sequencer control and instruction-memory signals.
// The STEP line exists only when SEQ_STEP_EN is defined.
interface instr_sequencer_if #(
    parameter int PC_W = 4
) ();
    import seq_pkg::*;

    logic                start;
    logic                run;
`ifdef SEQ_STEP_EN
    logic                step;
`endif
    logic                imem_req;
    logic [PC_W-1:0]     imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_data;
    logic [INSTR_W-1:0]  instr;
    logic                alu_en;
    logic                acc_we;
    logic [PC_W-1:0]     pc;
    logic                busy;
    logic                fault;

`ifdef SEQ_STEP_EN
    modport master (
        input  start, run, step, imem_ack, imem_data,
        output imem_req, imem_addr, instr, alu_en, acc_we, pc, busy, fault
    );
    modport slave (
        output start, run, step, imem_ack, imem_data,
        input  imem_req, imem_addr, instr, alu_en, acc_we, pc, busy, fault
    );
`else
    modport master (
        input  start, run, imem_ack, imem_data,
        output imem_req, imem_addr, instr, alu_en, acc_we, pc, busy, fault
    );
    modport slave (
        output start, run, imem_ack, imem_data,
        input  imem_req, imem_addr, instr, alu_en, acc_we, pc, busy, fault
    );
`endif

endinterface

// File: rtl/instr_sequencer_watchdog.sv
// Fetch watchdog: 8-bit up-counter with clear and enable; o_tc flags that the
// next enabled increment would reach the timeout limit.
module seq_watchdog #(
    parameter logic [7:0] TC_VAL = 8'd7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [7:0] r_count;

    // Wait-cycle counter, clear has priority over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch/execute FSM, program counter, instruction register.
// Optional single-step mode (STEP input, PAUSE state) enabled by SEQ_STEP_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.master   bus
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_FETCH = ST_FETCH;
    localparam logic [2:0] S_EXEC  = ST_EXEC;
    localparam logic [2:0] S_FAULT = ST_FAULT;
    localparam logic [2:0] S_PAUSE = ST_PAUSE;

    // Counter value at which one more unacknowledged fetch cycle means timeout
    localparam logic [7:0] WD_TC = 8'(TIMEOUT - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_next;
    logic [INSTR_W-1:0]  r_instr;
    logic [INSTR_W-1:0]  w_instr_next;
    logic                r_imem_req;
    logic                r_alu_en;
    logic                r_acc_we;
    logic                r_busy;
    logic                r_fault;
    logic                w_wd_clr;
    logic                w_wd_en;
    logic                w_wd_tc;

    seq_watchdog #(
        .TC_VAL (WD_TC)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_wd_clr),
        .i_en  (w_wd_en),
        .o_tc  (w_wd_tc)
    );

    // Next-state, PC, instruction register and watchdog control
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_instr_next = r_instr;
        w_wd_clr     = 1'b1;
        w_wd_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_pc_next    = {PC_W{1'b0}};
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FETCH: begin
                // An ack in the timeout cycle still wins over the fault
                if (bus.imem_ack) begin
                    w_instr_next = bus.imem_data;
                    w_state_next = S_EXEC;
                end else if (w_wd_tc) begin
                    w_state_next = S_FAULT;
                end else begin
                    w_wd_clr     = 1'b0;
                    w_wd_en      = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_EXEC: begin
                w_pc_next = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
                if (bus.run) begin
`ifdef SEQ_STEP_EN
                    w_state_next = S_PAUSE;
`else
                    w_state_next = S_FETCH;
`endif
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
`ifdef SEQ_STEP_EN
            S_PAUSE: begin
                if (!bus.run) begin
                    w_state_next = S_IDLE;
                end else if (bus.step) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_PAUSE;
                end
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, PC and instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= {PC_W{1'b0}};
            r_instr <= {INSTR_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_instr <= w_instr_next;
        end
    end

    // Outputs are decoded from the next state so they register with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_imem_req <= 1'b0;
            r_alu_en   <= 1'b0;
            r_acc_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_imem_req <= (w_state_next == S_FETCH);
            r_alu_en   <= (w_state_next == S_EXEC);
            r_acc_we   <= (w_state_next == S_EXEC) && instr_acc_ce(w_instr_next);
            r_busy     <= (w_state_next != S_IDLE) && (w_state_next != S_FAULT);
            r_fault    <= (w_state_next == S_FAULT);
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.pc        = r_pc;
    assign bus.instr     = r_instr;
    assign bus.alu_en    = r_alu_en;
    assign bus.acc_we    = r_acc_we;
    assign bus.busy      = r_busy;
    assign bus.fault     = r_fault;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Control unit for the 4-bit core: fetches 6-bit instructions from instruction memory over a req/ack handshake, holds them in an instruction register for the decoder and sequences one ALU/accumulator operation per instruction. Sits between instruction memory and the decoder, ALU, register file and accumulator. Owns the program counter, run/idle control and a fetch watchdog.

## Interface
- `PC_W`, 4: program counter width; program space is 2^PC_W words.
- `TIMEOUT`, 8: maximum fetch wait cycles before a fault; range 1..255.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous reset, active-high.
- `START` in 1: level, sampled in IDLE; begins execution at PC=0.
- `RUN` in 1: level; while high, execution continues past each instruction.
- `IMEM_REQ` out 1: fetch request.
- `IMEM_ADDR` out PC_W: fetch address, equal to PC.
- `IMEM_ACK` in 1: memory returns data this cycle.
- `IMEM_DATA` in 6: instruction word, valid when IMEM_ACK=1.
- `INSTR` out 6: instruction register, fed to the decoder.
- `ALU_EN` out 1: one-cycle execute strobe.
- `ACC_WE` out 1: accumulator write; equals INSTR[5] during EXEC, else 0.
- `PC` out PC_W: current program counter.
- `BUSY` out 1: state is not IDLE and not FAULT.
- `FAULT` out 1: fetch timeout occurred.
- `STEP` in 1: present only with SEQ_STEP_EN; single-step advance pulse.

## Operation
- Reset values: state IDLE; PC=0; INSTR=0; watchdog=0. All outputs are 0 except IMEM_ADDR, which equals PC=0.
- IDLE: when START=1, set PC=0 and go to FETCH. When START=0, stay.
- FETCH: IMEM_REQ=1 with IMEM_ADDR=PC held stable. When IMEM_ACK=1, load INSTR<=IMEM_DATA, clear the watchdog and go to EXEC. Otherwise increment the watchdog. When the watchdog reaches TIMEOUT with no ack, go to FAULT.
- EXEC: ALU_EN=1 and ACC_WE=INSTR[5] for exactly one cycle. PC<=PC+1 modulo 2^PC_W, so 2^PC_W-1 wraps to 0. Next state is FETCH if RUN=1, otherwise IDLE.
- FAULT: FAULT=1, IMEM_REQ=0. PC and INSTR are frozen. The only exit is RST.
- RUN is sampled only in EXEC. Dropping RUN mid-fetch lets the current instruction finish.
- START outside IDLE is ignored.
- INSTR holds its value between fetches and in IDLE, so decoder outputs stay stable.

## Timing
- With zero-wait memory (ack in the first FETCH cycle), each instruction takes 2 cycles: FETCH, then EXEC. Each wait cycle adds one cycle.
- IMEM_REQ deasserts in the cycle after the ack.
- An ack is accepted only in the same cycle IMEM_REQ=1; an ack outside FETCH is ignored.
- An ack in the same cycle the watchdog reaches TIMEOUT wins: data is loaded and the state goes to EXEC.
- RST asserted mid-operation clears everything immediately (asynchronous), including FAULT. An in-flight request is abandoned.
- INSTR updates on the clock edge that samples the ack; ALU_EN follows in the next cycle.

## Configuration
- `SEQ_STEP_EN` defined:
  - Adds the STEP port and a PAUSE state.
  - EXEC with RUN=1 goes to PAUSE, not FETCH.
  - PAUSE goes to FETCH on STEP=1, and to IDLE if RUN=0.
  - BUSY=1 in PAUSE.
- `SEQ_STEP_EN` undefined: no STEP port and no PAUSE state; EXEC goes directly to FETCH.

## Structure
- Shared package `seq_pkg`:
  - state enum (IDLE, FETCH, EXEC, FAULT, PAUSE);
  - instruction field constants: ADDR [1:0], OP_CODE [4:2], ACC_CE bit 5;
  - INSTR_W=6.
- Sub-module `seq_watchdog`: 8-bit counter with clear, enable and terminal-count output, reset asynchronously by RST.
- Top level holds the FSM, PC and instruction register.

## Test plan
- Reset: RST=1 mid-FETCH → next cycle state IDLE, PC=0, INSTR=0, IMEM_REQ=0, FAULT=0.
- Zero-wait run: START=1, RUN=1, memory acks immediately with words 0x25, 0x0A → INSTR=0x25 then ALU_EN=1 with ACC_WE=1; next INSTR=0x0A with ACC_WE=0; each instruction takes 2 cycles.
- Wait states: ack delayed 3 cycles → IMEM_REQ high for 4 cycles, IMEM_ADDR constant, one ALU_EN pulse.
- Wrap: PC_W=4, run 17 instructions → PC goes 15→0 and address 0 is fetched again.
- Timeout: TIMEOUT=8, no ack → FAULT=1 after 8 FETCH cycles, BUSY=0, REQ=0; an ack arriving on the 8th cycle instead → EXEC with no fault.
- RUN drop: RUN=0 asserted during FETCH → that instruction executes, then IDLE. With SEQ_STEP_EN: PAUSE holds until a STEP pulse, then exactly one further instruction executes.
